// File: rtl/qdr_arb_pkg.sv
// Shared definitions for the two-port QDR user-interface arbiter.
package qdr_arb_pkg;

  localparam logic PORT_FABRIC = 1'b0;
  localparam logic PORT_CPU    = 1'b1;

  typedef enum logic [0:0] {
    WAIT_PHY = 1'b0,
    RUN      = 1'b1
  } arb_state_e;

endpackage

// File: rtl/qdr_arb_tag_fifo.sv
// In-order tag FIFO: records which port issued each outstanding read.
module qdr_arb_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic clk0,
  input  logic reset_n,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic pop_tag,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign pop_tag   = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer, storage and occupancy update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= {DEPTH{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/qdr_arbiter.sv
// Two-port arbiter in front of a QDR controller user interface.
// Optional macro QDR_ARB_PRIORITY_EN: fixed priority to port 0 instead of round-robin.
module qdr_arbiter
  import qdr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int BW_WIDTH   = 2,
  parameter int ADDR_WIDTH = 22,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                      clk0,
  input  logic                      reset_n,
  input  logic                      p0_rd_strb,
  input  logic                      p0_wr_strb,
  input  logic [ADDR_WIDTH-1:0]     p0_addr,
  input  logic [2*DATA_WIDTH-1:0]   p0_wr_data,
  input  logic [2*BW_WIDTH-1:0]     p0_wr_be,
  output logic                      p0_ack,
  output logic [2*DATA_WIDTH-1:0]   p0_rd_data,
  output logic                      p0_rd_dvld,
  input  logic                      p1_rd_strb,
  input  logic                      p1_wr_strb,
  input  logic [ADDR_WIDTH-1:0]     p1_addr,
  input  logic [2*DATA_WIDTH-1:0]   p1_wr_data,
  input  logic [2*BW_WIDTH-1:0]     p1_wr_be,
  output logic                      p1_ack,
  output logic [2*DATA_WIDTH-1:0]   p1_rd_data,
  output logic                      p1_rd_dvld,
  input  logic                      phy_rdy,
  output logic                      usr_rd_strb,
  output logic                      usr_wr_strb,
  output logic [ADDR_WIDTH-1:0]     usr_addr,
  output logic [2*DATA_WIDTH-1:0]   usr_wr_data,
  output logic [2*BW_WIDTH-1:0]     usr_wr_be,
  input  logic [2*DATA_WIDTH-1:0]   usr_rd_data,
  input  logic                      usr_rd_dvld,
  output logic                      rd_orphan
);

  localparam int DW2 = 2 * DATA_WIDTH;
  localparam int BW2 = 2 * BW_WIDTH;

  arb_state_e             state_q, state_d;
  logic                   prio_q, prio_d;
  logic [1:0]             ack_q, ack_d;
  logic                   usr_rd_strb_q, usr_rd_strb_d, usr_wr_strb_q, usr_wr_strb_d;
  logic [ADDR_WIDTH-1:0]  usr_addr_q, usr_addr_d;
  logic [DW2-1:0]         usr_wr_data_q, usr_wr_data_d;
  logic [BW2-1:0]         usr_wr_be_q, usr_wr_be_d;
  logic [1:0]             rd_dvld_q, rd_dvld_d;
  logic [DW2-1:0]         p0_rd_data_q, p0_rd_data_d, p1_rd_data_q, p1_rd_data_d;
  logic                   orphan_q, orphan_d;

  logic [1:0] elig_s;
  logic       run_s, gnt_vld_s, gnt_port_s, gnt_wr_s, pop_s;
  logic       fifo_full_s, fifo_empty_s, pop_tag_s;

  // The !ack_q mask keeps a still-held request from being granted twice.
  assign run_s     = (state_q == RUN) && phy_rdy;
  assign elig_s[0] = run_s && (p0_rd_strb || p0_wr_strb) && !ack_q[0] && (p0_wr_strb || !fifo_full_s);
  assign elig_s[1] = run_s && (p1_rd_strb || p1_wr_strb) && !ack_q[1] && (p1_wr_strb || !fifo_full_s);
  assign gnt_vld_s = |elig_s;
  assign gnt_wr_s  = (gnt_port_s == PORT_CPU) ? p1_wr_strb : p0_wr_strb;
  assign pop_s     = usr_rd_dvld && !fifo_empty_s;

  // Grant selection: one winner per cycle
  always_comb begin
`ifdef QDR_ARB_PRIORITY_EN
    if (elig_s[PORT_FABRIC]) begin
      gnt_port_s = PORT_FABRIC;
    end else begin
      gnt_port_s = PORT_CPU;
    end
`else
    case (elig_s)
      2'b01:   gnt_port_s = PORT_FABRIC;
      2'b10:   gnt_port_s = PORT_CPU;
      2'b11:   gnt_port_s = prio_q;
      default: gnt_port_s = PORT_FABRIC;
    endcase
`endif
  end

  qdr_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk0     (clk0),
    .reset_n  (reset_n),
    .push     (gnt_vld_s && !gnt_wr_s),
    .push_tag (gnt_port_s),
    .pop      (pop_s),
    .pop_tag  (pop_tag_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Next-state: FSM, command issue and read-return routing
  always_comb begin
    case (state_q)
      WAIT_PHY: state_d = phy_rdy ? RUN : WAIT_PHY;
      RUN:      state_d = phy_rdy ? RUN : WAIT_PHY;
      default:  state_d = WAIT_PHY;
    endcase
    prio_d        = prio_q;
    ack_d         = 2'b00;
    usr_rd_strb_d = 1'b0;
    usr_wr_strb_d = 1'b0;
    usr_addr_d    = usr_addr_q;
    usr_wr_data_d = usr_wr_data_q;
    usr_wr_be_d   = usr_wr_be_q;
    if (gnt_vld_s) begin
      ack_d[gnt_port_s] = 1'b1;
      usr_wr_strb_d     = gnt_wr_s;
      usr_rd_strb_d     = !gnt_wr_s;
      usr_addr_d        = (gnt_port_s == PORT_CPU) ? p1_addr    : p0_addr;
      usr_wr_data_d     = (gnt_port_s == PORT_CPU) ? p1_wr_data : p0_wr_data;
      usr_wr_be_d       = (gnt_port_s == PORT_CPU) ? p1_wr_be   : p0_wr_be;
      prio_d            = !gnt_port_s;
    end else begin
      prio_d = prio_q;
    end
    rd_dvld_d    = 2'b00;
    p0_rd_data_d = p0_rd_data_q;
    p1_rd_data_d = p1_rd_data_q;
    if (pop_s) begin
      rd_dvld_d[pop_tag_s] = 1'b1;
      if (pop_tag_s == PORT_CPU) begin
        p1_rd_data_d = usr_rd_data;
      end else begin
        p0_rd_data_d = usr_rd_data;
      end
    end else begin
      rd_dvld_d = 2'b00;
    end
    orphan_d = orphan_q || (usr_rd_dvld && fifo_empty_s);
  end

  // Registered state and outputs
  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_PHY;
      prio_q        <= PORT_FABRIC;
      ack_q         <= 2'b00;
      usr_rd_strb_q <= 1'b0;
      usr_wr_strb_q <= 1'b0;
      usr_addr_q    <= {ADDR_WIDTH{1'b0}};
      usr_wr_data_q <= {DW2{1'b0}};
      usr_wr_be_q   <= {BW2{1'b0}};
      rd_dvld_q     <= 2'b00;
      p0_rd_data_q  <= {DW2{1'b0}};
      p1_rd_data_q  <= {DW2{1'b0}};
      orphan_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      ack_q         <= ack_d;
      usr_rd_strb_q <= usr_rd_strb_d;
      usr_wr_strb_q <= usr_wr_strb_d;
      usr_addr_q    <= usr_addr_d;
      usr_wr_data_q <= usr_wr_data_d;
      usr_wr_be_q   <= usr_wr_be_d;
      rd_dvld_q     <= rd_dvld_d;
      p0_rd_data_q  <= p0_rd_data_d;
      p1_rd_data_q  <= p1_rd_data_d;
      orphan_q      <= orphan_d;
    end
  end

  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p0_rd_dvld  = rd_dvld_q[0];
  assign p1_rd_dvld  = rd_dvld_q[1];
  assign p0_rd_data  = p0_rd_data_q;
  assign p1_rd_data  = p1_rd_data_q;
  assign usr_rd_strb = usr_rd_strb_q;
  assign usr_wr_strb = usr_wr_strb_q;
  assign usr_addr    = usr_addr_q;
  assign usr_wr_data = usr_wr_data_q;
  assign usr_wr_be   = usr_wr_be_q;
  assign rd_orphan   = orphan_q;

endmodule
